// File: rtl/vga_timing.sv
// Raster timing generator: pixel/line counters, sync and blanking strobes,
// start-of-frame pulse and completed-frame counter, all registered.
module vga_timing #(
  parameter int H_ACTIVE  = 1024,
  parameter int H_FP      = 24,
  parameter int H_SYNC    = 136,
  parameter int H_BP      = 160,
  parameter int V_ACTIVE  = 768,
  parameter int V_FP      = 3,
  parameter int V_SYNC    = 6,
  parameter int V_BP      = 29,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int FCNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [10:0]       hcount,
  output logic [10:0]       vcount,
  output logic              hsync,
  output logic              vsync,
  output logic              hblnk,
  output logic              vblnk,
  output logic              frame_start,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_BLNK = 11'(H_ACTIVE);
  localparam logic [10:0] V_BLNK = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
      H_TOTAL > 2047 || V_TOTAL > 2047 || FCNT_W < 1) begin : g_bad_geometry
    $error("vga_timing: invalid raster geometry");
  end

  logic [10:0] h_nxt;
  logic [10:0] v_nxt;
  logic        wrap;

  // Next raster position; strobes are derived from it so they line up with the counters.
  always_comb begin
    h_nxt = hcount;
    v_nxt = vcount;
    wrap  = 1'b0;
    if (en) begin
      if (hcount == H_LAST) begin
        h_nxt = '0;
        if (vcount == V_LAST) begin
          v_nxt = '0;
          wrap  = 1'b1;
        end else begin
          v_nxt = vcount + 11'd1;
        end
      end else begin
        h_nxt = hcount + 11'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcount      <= '0;
      vcount      <= '0;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      hcount      <= h_nxt;
      vcount      <= v_nxt;
      hblnk       <= (h_nxt >= H_BLNK);
      vblnk       <= (v_nxt >= V_BLNK);
      hsync       <= (h_nxt >= HS_BEG && h_nxt < HS_END) ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= (v_nxt >= VS_BEG && v_nxt < VS_END) ? VSYNC_POL : ~VSYNC_POL;
      frame_start <= wrap;
      if (wrap) frame_cnt <= frame_cnt + FCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench: full 1024x768 geometry for line timing, and a tiny
// 7x6 geometry (active-high syncs, 2-bit frame counter) for frame behaviour.
module tb_vga_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_f, en_f, rst_n_s, en_s;
  logic [10:0] hc_f, vc_f, hc_s, vc_s;
  logic        hs_f, vs_f, hb_f, vb_f, fs_f;
  logic        hs_s, vs_s, hb_s, vb_s, fs_s;
  logic [15:0] fc_f;
  logic [1:0]  fc_s;

  int total = 0;
  int bad   = 0;

  vga_timing dut_f (
    .clk(clk), .rst_n(rst_n_f), .en(en_f),
    .hcount(hc_f), .vcount(vc_f), .hsync(hs_f), .vsync(vs_f),
    .hblnk(hb_f), .vblnk(vb_f), .frame_start(fs_f), .frame_cnt(fc_f)
  );

  // H 4/1/1/1 -> H_TOTAL 7, hsync at col 5; V 3/1/1/1 -> V_TOTAL 6, vsync at line 4
  vga_timing #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .FCNT_W(2)
  ) dut_s (
    .clk(clk), .rst_n(rst_n_s), .en(en_s),
    .hcount(hc_s), .vcount(vc_s), .hsync(hs_s), .vsync(vs_s),
    .hblnk(hb_s), .vblnk(vb_s), .frame_start(fs_s), .frame_cnt(fc_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n_f = 1'b0; en_f = 1'b1;
    rst_n_s = 1'b0; en_s = 1'b1;
    repeat (3) tick();
    total++;
    if (hc_f !== 11'd0 || vc_f !== 11'd0) begin
      bad++; $display("FAIL reset_cnt_f got h=%0d v=%0d want 0 0", hc_f, vc_f);
    end
    total++;
    if ({hs_f, vs_f} !== 2'b11) begin
      bad++; $display("FAIL reset_sync_f got %b want 11", {hs_f, vs_f});
    end
    total++;
    if ({hb_f, vb_f} !== 2'b00) begin
      bad++; $display("FAIL reset_blnk_f got %b want 00", {hb_f, vb_f});
    end
    total++;
    if (fs_f !== 1'b0 || fc_f !== 16'd0) begin
      bad++; $display("FAIL reset_frame_f got fs=%b fc=%0d want 0 0", fs_f, fc_f);
    end
    total++;
    if ({hs_s, vs_s} !== 2'b00) begin
      bad++; $display("FAIL reset_sync_s got %b want 00", {hs_s, vs_s});
    end
    total++;
    if (hc_s !== 11'd0 || vc_s !== 11'd0 || fc_s !== 2'd0 || fs_s !== 1'b0) begin
      bad++; $display("FAIL reset_s got h=%0d v=%0d fc=%0d fs=%b want 0 0 0 0", hc_s, vc_s, fc_s, fs_s);
    end
    rst_n_f = 1'b1; en_f = 1'b0;
    rst_n_s = 1'b1; en_s = 1'b0;
    tick();
    total++;
    if (hc_f !== 11'd0 || vc_f !== 11'd0 || fs_f !== 1'b0) begin
      bad++; $display("FAIL release_f got h=%0d v=%0d fs=%b want 0 0 0", hc_f, vc_f, fs_f);
    end
  endtask

  task automatic test_hline();
    int eh = 0, ev = 0;
    int low = 0, first_hs = -1, last_hs = -1, first_hb = -1;
    logic exp_hb, exp_hs;
    en_f = 1'b1;
    for (int i = 0; i < 1344; i++) begin
      tick();
      if (eh == 1343) begin eh = 0; ev++; end else eh++;
      exp_hb = (eh >= 1024);
      exp_hs = !(eh >= 1048 && eh < 1184);
      total++;
      if (hc_f !== 11'(eh) || vc_f !== 11'(ev) || hb_f !== exp_hb || hs_f !== exp_hs) begin
        bad++;
        $display("FAIL hline got h=%0d v=%0d hb=%b hs=%b want h=%0d v=%0d hb=%b hs=%b",
                 hc_f, vc_f, hb_f, hs_f, eh, ev, exp_hb, exp_hs);
      end
      if (hs_f === 1'b0) begin
        low++;
        if (first_hs < 0) first_hs = int'(hc_f);
        last_hs = int'(hc_f);
      end
      if (hb_f === 1'b1 && first_hb < 0) first_hb = int'(hc_f);
    end
    total++;
    if (low != 136 || first_hs != 1048 || last_hs != 1183) begin
      bad++; $display("FAIL hsync_window got n=%0d %0d..%0d want 136 1048..1183", low, first_hs, last_hs);
    end
    total++;
    if (first_hb != 1024) begin
      bad++; $display("FAIL hblnk_rise got %0d want 1024", first_hb);
    end
    total++;
    if (hc_f !== 11'd0 || vc_f !== 11'd1 || hb_f !== 1'b0 || vb_f !== 1'b0 || vs_f !== 1'b1 || fs_f !== 1'b0) begin
      bad++; $display("FAIL line_end got h=%0d v=%0d hb=%b vb=%b vs=%b fs=%b want 0 1 0 0 1 0",
                      hc_f, vc_f, hb_f, vb_f, vs_f, fs_f);
    end
  endtask

  task automatic test_enable_gating();
    int eh;
    logic prev_hs, prev_hb;
    repeat (1046) tick();
    eh = 1046;
    total++;
    if (hc_f !== 11'd1046 || vc_f !== 11'd1) begin
      bad++; $display("FAIL gate_start got h=%0d v=%0d want 1046 1", hc_f, vc_f);
    end
    for (int k = 0; k < 36; k++) begin
      prev_hs = hs_f; prev_hb = hb_f;
      en_f = (k % 3 == 0);
      tick();
      if (en_f) eh++;
      total++;
      if (hc_f !== 11'(eh) || vc_f !== 11'd1 || hs_f !== !(eh >= 1048 && eh < 1184)) begin
        bad++; $display("FAIL gate_adv got h=%0d hs=%b want h=%0d", hc_f, hs_f, eh);
      end
      if (!en_f) begin
        total++;
        if (hs_f !== prev_hs || hb_f !== prev_hb) begin
          bad++; $display("FAIL gate_hold got hs=%b hb=%b want %b %b", hs_f, hb_f, prev_hs, prev_hb);
        end
      end
    end
    rst_n_f = 1'b0; en_f = 1'b1;
    tick();
    total++;
    if (hc_f !== 11'd0 || vc_f !== 11'd0 || hs_f !== 1'b1 || hb_f !== 1'b0 || fs_f !== 1'b0 || fc_f !== 16'd0) begin
      bad++; $display("FAIL midline_reset_f got h=%0d v=%0d hs=%b hb=%b fs=%b fc=%0d want 0 0 1 0 0 0",
                      hc_f, vc_f, hs_f, hb_f, fs_f, fc_f);
    end
    rst_n_f = 1'b1; en_f = 1'b0;
  endtask

  task automatic test_frame();
    int sh = 0, sv = 0, sfc = 0, cyc = 0, last_fs = -1, pulses = 0;
    logic wrap;
    en_s = 1'b1;
    for (int i = 0; i < 126; i++) begin
      tick();
      cyc++;
      wrap = 1'b0;
      if (sh == 6) begin
        sh = 0;
        if (sv == 5) begin sv = 0; wrap = 1'b1; sfc = (sfc + 1) % 4; end else sv++;
      end else sh++;
      total++;
      if (hc_s !== 11'(sh) || vc_s !== 11'(sv) || hs_s !== (sh == 5) || vs_s !== (sv == 4) ||
          hb_s !== (sh >= 4) || vb_s !== (sv >= 3) || fs_s !== wrap || fc_s !== 2'(sfc)) begin
        bad++;
        $display("FAIL frame got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b fs=%b fc=%0d want h=%0d v=%0d fs=%b fc=%0d",
                 hc_s, vc_s, hs_s, vs_s, hb_s, vb_s, fs_s, fc_s, sh, sv, wrap, sfc);
      end
      if (fs_s === 1'b1) begin
        pulses++;
        if (last_fs >= 0) begin
          total++;
          if (cyc - last_fs != 42) begin
            bad++; $display("FAIL frame_period got %0d want 42", cyc - last_fs);
          end
        end
        last_fs = cyc;
      end
    end
    total++;
    if (pulses != 3 || fc_s !== 2'd3 || fs_s !== 1'b1 || hc_s !== 11'd0 || vc_s !== 11'd0) begin
      bad++; $display("FAIL three_frames got pulses=%0d fc=%0d fs=%b want 3 3 1", pulses, fc_s, fs_s);
    end
    en_s = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (fs_s !== 1'b0 || hc_s !== 11'd0 || vc_s !== 11'd0 || fc_s !== 2'd3 || hs_s !== 1'b0 || vs_s !== 1'b0) begin
        bad++; $display("FAIL fs_hold got fs=%b h=%0d v=%0d fc=%0d want 0 0 0 3", fs_s, hc_s, vc_s, fc_s);
      end
    end
  endtask

  task automatic test_mid_reset();
    en_s = 1'b1;
    repeat (17) tick();
    total++;
    if (hc_s !== 11'd3 || vc_s !== 11'd2 || fc_s !== 2'd3) begin
      bad++; $display("FAIL premid got h=%0d v=%0d fc=%0d want 3 2 3", hc_s, vc_s, fc_s);
    end
    rst_n_s = 1'b0;
    tick();
    total++;
    if (hc_s !== 11'd0 || vc_s !== 11'd0 || fc_s !== 2'd0 || fs_s !== 1'b0 || hs_s !== 1'b0 || vb_s !== 1'b0) begin
      bad++; $display("FAIL mid_reset got h=%0d v=%0d fc=%0d fs=%b want 0 0 0 0", hc_s, vc_s, fc_s, fs_s);
    end
    rst_n_s = 1'b1;
    tick();
    total++;
    if (hc_s !== 11'd1 || vc_s !== 11'd0 || fs_s !== 1'b0) begin
      bad++; $display("FAIL post_reset got h=%0d v=%0d fs=%b want 1 0 0", hc_s, vc_s, fs_s);
    end
  endtask

  task automatic test_fcnt_wrap();
    logic [1:0] want [4];
    int pulses = 0, cyc = 0, last_fs = -1;
    want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3; want[3] = 2'd0;
    en_s = 1'b1;
    while (pulses < 4 && cyc < 300) begin
      tick();
      cyc++;
      if (fs_s === 1'b1) begin
        total++;
        if (fc_s !== want[pulses]) begin
          bad++; $display("FAIL fcnt_seq got %0d want %0d", fc_s, want[pulses]);
        end
        if (last_fs >= 0) begin
          total++;
          if (cyc - last_fs != 42) begin
            bad++; $display("FAIL fcnt_period got %0d want 42", cyc - last_fs);
          end
        end else begin
          total++;
          if (cyc != 41) begin
            bad++; $display("FAIL first_wrap got %0d want 41", cyc);
          end
        end
        last_fs = cyc;
        pulses++;
      end
    end
    total++;
    if (pulses != 4) begin
      bad++; $display("FAIL fcnt_timeout got %0d pulses want 4", pulses);
    end
    en_s = 1'b0;
  endtask

  initial begin
    rst_n_f = 1'b0; en_f = 1'b0;
    rst_n_s = 1'b0; en_s = 1'b0;
    test_reset();
    test_hline();
    test_enable_gating();
    test_frame();
    test_mid_reset();
    test_fcnt_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
